// File: rtl/qsys_irq_ctrl_pkg.sv
// Shared constants for the Avalon-MM interrupt controller: register map, line count limit
// and VECTOR layout.
package qsys_irq_ctrl_pkg;

  localparam int unsigned MAX_IRQ       = 16;
  localparam int unsigned VEC_VALID_BIT = 15;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_RAW     = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_FORCE   = 3'd5;

endpackage

// File: rtl/qsys_irq_prio_enc.sv
// Lowest-index-first priority encoder over the full MAX_IRQ request vector.
module qsys_irq_prio_enc
  import qsys_irq_ctrl_pkg::*;
(
  input  logic [MAX_IRQ-1:0] req_i,
  output logic [3:0]         idx_o,
  output logic               valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    // Scan downward so the lowest set bit is the final assignment.
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 4'(i);
    end
  end

endmodule

// File: rtl/qsys_irq_ctrl.sv
// Avalon-MM interrupt controller with per-line edge/level mode, W1C pending and force.
// Define QSYS_IRQ_CTRL_SYNC_EN to add a 2-flop synchronizer on every irq_in bit.
module qsys_irq_ctrl
  import qsys_irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] en_q, en_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [15:0]        readdata_q, readdata_d;

  logic               wr_en;
  logic [NUM_IRQ-1:0] wdata, w1c, force_set, edge_ev;
  logic [MAX_IRQ-1:0] pend_ext, en_ext, edge_ext, raw_ext, act_ext;
  logic [15:0]        vector;
  logic [3:0]         vec_idx;
  logic               vec_valid;
  logic               unused_wdata;

`ifdef QSYS_IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  // Only the low NUM_IRQ bits of writedata carry meaning.
  assign unused_wdata = ^writedata;

  always_comb begin
    wr_en      = chipselect & ~write_n;
    wdata      = writedata[NUM_IRQ-1:0];
    w1c        = (wr_en && address == ADDR_PENDING) ? wdata : '0;
    force_set  = (wr_en && address == ADDR_FORCE) ? wdata : '0;
    edge_ev    = irq_s & ~irq_prev_q;
    irq_prev_d = irq_s;
    // Edge lines: set beats W1C. Level lines track the input, so W1C cannot clear them.
    pend_d     = (edge_q & (edge_ev | force_set | (pend_q & ~w1c)))
               | (~edge_q & (irq_s | force_set));
    en_d       = (wr_en && address == ADDR_ENABLE) ? wdata : en_q;
    edge_d     = (wr_en && address == ADDR_EDGE) ? wdata : edge_q;
  end

  always_comb begin
    pend_ext = '0;
    en_ext   = '0;
    edge_ext = '0;
    raw_ext  = '0;
    pend_ext[NUM_IRQ-1:0] = pend_q;
    en_ext[NUM_IRQ-1:0]   = en_q;
    edge_ext[NUM_IRQ-1:0] = edge_q;
    raw_ext[NUM_IRQ-1:0]  = irq_s;
    act_ext  = pend_ext & en_ext;
  end

  qsys_irq_prio_enc u_prio_enc (
    .req_i   (act_ext),
    .idx_o   (vec_idx),
    .valid_o (vec_valid)
  );

  always_comb begin
    vector                = '0;
    vector[VEC_VALID_BIT] = vec_valid;
    vector[3:0]           = vec_idx;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_PENDING: readdata_d = pend_ext;
      ADDR_ENABLE:  readdata_d = en_ext;
      ADDR_EDGE:    readdata_d = edge_ext;
      ADDR_RAW:     readdata_d = raw_ext;
      ADDR_VECTOR:  readdata_d = vector;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= '0;
      pend_q     <= '0;
      en_q       <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(pend_q & en_q);

endmodule

// File: tb/tb_qsys_irq_ctrl.sv
// Self-checking bench for qsys_irq_ctrl: behavioural model compared every cycle plus
// directed literal checks. Honours QSYS_IRQ_CTRL_SYNC_EN for input latency.
module tb_qsys_irq_ctrl;

  localparam int NumIrq = 8;
  localparam logic [15:0] Mask = 16'h00FF;
`ifdef QSYS_IRQ_CTRL_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic              clk;
  logic              reset;
  logic [NumIrq-1:0] irq_in;
  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic              irq;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  qsys_irq_ctrl #(.NUM_IRQ(NumIrq)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [15:0] m_pend, m_en, m_edge, m_rd;
  logic [15:0] m_hist [1:3];  // irq_in as seen 1, 2, 3 edges ago
  logic [15:0] m_in, m_eff, m_prv, m_nxt, m_vec, m_rdval;
  logic        m_wr, m_found, m_irq;

  always_comb begin
    m_in  = {8'h00, irq_in};
    m_eff = (Lat == 0) ? m_in : m_hist[2];
    m_prv = (Lat == 0) ? m_hist[1] : m_hist[3];
    m_wr  = chipselect && !write_n;
    m_nxt = 16'h0;
    for (int i = 0; i < NumIrq; i++) begin
      if (m_edge[i]) begin
        if ((m_wr && address == 3'd5 && writedata[i]) || (m_eff[i] && !m_prv[i]))
          m_nxt[i] = 1'b1;
        else if (m_wr && address == 3'd0 && writedata[i])
          m_nxt[i] = 1'b0;
        else
          m_nxt[i] = m_pend[i];
      end else begin
        m_nxt[i] = m_eff[i] || (m_wr && address == 3'd5 && writedata[i]);
      end
    end
    m_vec   = 16'h0;
    m_found = 1'b0;
    for (int i = 0; i < NumIrq; i++) begin
      if (!m_found && m_pend[i] && m_en[i]) begin
        m_vec   = 16'h8000 + 16'(i);
        m_found = 1'b1;
      end
    end
    case (address)
      3'd0:    m_rdval = m_pend;
      3'd1:    m_rdval = m_en;
      3'd2:    m_rdval = m_edge;
      3'd3:    m_rdval = m_eff;
      3'd4:    m_rdval = m_vec;
      default: m_rdval = 16'h0;
    endcase
    m_irq = |(m_pend & m_en);
  end

  always @(posedge clk) begin
    if (reset) begin
      m_pend    <= 16'h0;
      m_en      <= 16'h0;
      m_edge    <= 16'h0;
      m_rd      <= 16'h0;
      m_hist[1] <= 16'h0;
      m_hist[2] <= 16'h0;
      m_hist[3] <= 16'h0;
    end else begin
      m_pend    <= m_nxt;
      if (m_wr && address == 3'd1) m_en <= writedata & Mask;
      if (m_wr && address == 3'd2) m_edge <= writedata & Mask;
      m_rd      <= m_rdval;
      m_hist[1] <= m_in;
      m_hist[2] <= m_hist[1];
      m_hist[3] <= m_hist[2];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (irq !== m_irq) begin
        fails++;
        $display("FAIL model_irq at %0t: got %b expected %b", $time, irq, m_irq);
      end
      tests++;
      if (readdata !== m_rd) begin
        fails++;
        $display("FAIL model_readdata at %0t: got %h expected %h", $time, readdata, m_rd);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    step(1);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  logic [15:0] v;

  initial begin
    reset      = 1'b1;
    irq_in     = '0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0;
    step(2);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Reset state
    rd(3'd0, v); check("rst_pending", v, 16'h0000);
    rd(3'd1, v); check("rst_enable", v, 16'h0000);
    rd(3'd2, v); check("rst_edge", v, 16'h0000);
    rd(3'd4, v); check("rst_vector", v, 16'h0000);
    check("rst_irq", {15'h0, irq}, 16'h0000);

    // Edge mode on line 0
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    step(1);
    irq_in[0] = 1'b0;
    step(Lat);
    check("edge_irq_set", {15'h0, irq}, 16'h0001);
    rd(3'd0, v); check("edge_pending", v, 16'h0001);
    wr(3'd0, 16'h0001);
    check("edge_w1c_irq", {15'h0, irq}, 16'h0000);

    // Level mode on line 2
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0004);
    irq_in[2] = 1'b1;
    step(1 + Lat);
    check("level_irq_set", {15'h0, irq}, 16'h0001);
    wr(3'd0, 16'h0004);
    rd(3'd0, v); check("level_w1c_ignored", v, 16'h0004);
    irq_in[2] = 1'b0;
    step(1 + Lat);
    check("level_irq_drop", {15'h0, irq}, 16'h0000);
    rd(3'd0, v); check("level_pending_drop", v, 16'h0000);

    // RAW sample, unused bits and unmapped addresses
    irq_in = 8'h5A;
    step(Lat);
    rd(3'd3, v); check("raw_read", v, 16'h005A);
    irq_in = 8'h00;
    step(1 + Lat);
    wr(3'd1, 16'hFFFF);
    rd(3'd1, v); check("enable_width", v, 16'h00FF);
    wr(3'd6, 16'hFFFF);
    rd(3'd6, v); check("addr6_zero", v, 16'h0000);
    rd(3'd7, v); check("addr7_zero", v, 16'h0000);

    // Priority encoder via VECTOR
    wr(3'd2, 16'h00FF);
    wr(3'd1, 16'h0000);
    wr(3'd5, 16'h00A0);
    wr(3'd1, 16'h00FF);
    rd(3'd4, v); check("vector_a0_ff", v, 16'h8005);
    check("vector_irq", {15'h0, irq}, 16'h0001);
    wr(3'd1, 16'h0080);
    rd(3'd4, v); check("vector_a0_80", v, 16'h8007);
    wr(3'd1, 16'h0000);
    rd(3'd4, v); check("vector_none", v, 16'h0000);
    check("vector_none_irq", {15'h0, irq}, 16'h0000);

    // Edge event colliding with W1C on line 3
    wr(3'd0, 16'h00FF);
    irq_in[3] = 1'b1;
    step(Lat);
    wr(3'd0, 16'h0008);
    rd(3'd0, v); check("collision_set_wins", v, 16'h0008);
    irq_in[3] = 1'b0;
    wr(3'd0, 16'h0008);
    rd(3'd0, v); check("plain_w1c", v, 16'h0000);

    // FORCE in edge mode, then in level mode
    wr(3'd1, 16'h0010);
    wr(3'd5, 16'h0010);
    check("force_irq", {15'h0, irq}, 16'h0001);
    rd(3'd5, v); check("force_reads_zero", v, 16'h0000);
    rd(3'd0, v); check("force_pending", v, 16'h0010);
    wr(3'd0, 16'h0010);
    wr(3'd2, 16'h0000);
    wr(3'd5, 16'h0010);
    check("force_level_irq", {15'h0, irq}, 16'h0001);
    step(1);
    check("force_level_clear", {15'h0, irq}, 16'h0000);

    // Mid-operation reset
    wr(3'd2, 16'h00FF);
    wr(3'd1, 16'h00FF);
    wr(3'd5, 16'h003C);
    check("pre_reset_irq", {15'h0, irq}, 16'h0001);
    reset = 1'b1;
    step(1);
    check("reset_irq", {15'h0, irq}, 16'h0000);
    check("reset_readdata", readdata, 16'h0000);
    reset = 1'b0;
    rd(3'd0, v); check("post_reset_pending", v, 16'h0000);
    rd(3'd1, v); check("post_reset_enable", v, 16'h0000);
    rd(3'd2, v); check("post_reset_edge", v, 16'h0000);
    step(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
